datapath_sequencer: RTL and testbench

DATAPATH_SEQUENCER -- requirements
Module: datapath_sequencer

---
 rtl/datapath_sequencer.sv | 105 ++++++++++
 tb/tb_datapath_sequencer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/datapath_sequencer.sv
// datapath_sequencer
//   Moore sequencer for a shared-bus datapath. Each accepted command runs
//   SETUP -> CAPTURE -> HOLD -> DONE -> IDLE, one cycle per state. The bus
//   driver is on for SETUP/CAPTURE/HOLD, and the capture strobes fire only in
//   CAPTURE, so every capture has one cycle of setup and one cycle of hold.
//
// Ports
//   MainClock  in   sole clock, rising edge
//   MainReset  in   async active-low reset
//   Start      in   command request, sampled only in IDLE
//   Op[1:0]    in   00 LOAD_A, 01 LOAD_B, 10 ADD, 11 SUB (sampled with Start)
//   EnableIn   out  DataIn -> bus
//   EnableA    out  register A -> bus (reserved, held low)
//   EnableAlu  out  ALU result -> bus
//   LatchA     out  capture into register A
//   LatchB     out  capture into register B
//   AddSub     out  ALU mode, 1 = subtract
//   EnableOut  out  capture into output register
//   Busy       out  command in progress
//   Done       out  one-cycle completion pulse
module datapath_sequencer (
  input  logic       MainClock,
  input  logic       MainReset,
  input  logic       Start,
  input  logic [1:0] Op,
  output logic       EnableIn,
  output logic       EnableA,
  output logic       EnableAlu,
  output logic       LatchA,
  output logic       LatchB,
  output logic       AddSub,
  output logic       EnableOut,
  output logic       Busy,
  output logic       Done
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    CAPTURE = 3'd2,
    HOLD    = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [1:0] OP_LOAD_A = 2'b00;
  localparam logic [1:0] OP_LOAD_B = 2'b01;
  localparam logic [1:0] OP_SUB    = 2'b11;

  state_t     state, state_nxt;
  logic [1:0] op_q, op_nxt;
  logic       active_nxt;   // bus driver window in the next state
  logic       cap_nxt;      // capture cycle in the next state

  // Next-state decode. Op is only taken on the IDLE->SETUP edge so that
  // later changes on Op (or Start) cannot disturb a running command.
  always_comb begin
    state_nxt = state;
    op_nxt    = op_q;
    case (state)
      IDLE: if (Start) begin
        state_nxt = SETUP;
        op_nxt    = Op;
      end
      SETUP:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = HOLD;
      HOLD:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    active_nxt = (state_nxt == SETUP) || (state_nxt == CAPTURE) || (state_nxt == HOLD);
    cap_nxt    = (state_nxt == CAPTURE);
  end

  // Outputs are registered from the next state, so they line up with the
  // state register and have no combinational path from the inputs.
  always_ff @(posedge MainClock or negedge MainReset) begin
    if (!MainReset) begin
      state     <= IDLE;
      op_q      <= OP_LOAD_A;
      EnableIn  <= 1'b0;
      EnableA   <= 1'b0;
      EnableAlu <= 1'b0;
      LatchA    <= 1'b0;
      LatchB    <= 1'b0;
      AddSub    <= 1'b0;
      EnableOut <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      op_q      <= op_nxt;
      // op_nxt[1] splits loads (external data) from ALU ops.
      EnableIn  <= active_nxt && !op_nxt[1];
      EnableA   <= 1'b0;
      EnableAlu <= active_nxt && op_nxt[1];
      LatchA    <= cap_nxt && (op_nxt == OP_LOAD_A);
      LatchB    <= cap_nxt && (op_nxt == OP_LOAD_B);
      AddSub    <= active_nxt && (op_nxt == OP_SUB);
      EnableOut <= cap_nxt;
      Busy      <= active_nxt;
      Done      <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Testbench for datapath_sequencer: directed vector table, async reset
// corner cases, and a random run with protocol checks.
module tb_datapath_sequencer;

  logic       MainClock = 1'b0;
  logic       MainReset;
  logic       Start;
  logic [1:0] Op;
  logic       EnableIn, EnableA, EnableAlu, LatchA, LatchB, AddSub, EnableOut, Busy, Done;

  datapath_sequencer dut (
    .MainClock (MainClock),
    .MainReset (MainReset),
    .Start     (Start),
    .Op        (Op),
    .EnableIn  (EnableIn),
    .EnableA   (EnableA),
    .EnableAlu (EnableAlu),
    .LatchA    (LatchA),
    .LatchB    (LatchB),
    .AddSub    (AddSub),
    .EnableOut (EnableOut),
    .Busy      (Busy),
    .Done      (Done)
  );

  always #5 MainClock = ~MainClock;

  // Output vector bit order:
  // [8]EnableIn [7]EnableA [6]EnableAlu [5]LatchA [4]LatchB [3]AddSub [2]EnableOut [1]Busy [0]Done
  typedef struct {
    logic       start;
    logic [1:0] op;
    logic [8:0] exp;
  } vec_t;

  localparam logic [8:0] O_IDLE  = 9'b000000000;
  localparam logic [8:0] O_DONE  = 9'b000000001;
  localparam logic [8:0] LA_SET  = 9'b100000010;
  localparam logic [8:0] LA_CAP  = 9'b100100110;
  localparam logic [8:0] LB_CAP  = 9'b100010110;
  localparam logic [8:0] ADD_SET = 9'b001000010;
  localparam logic [8:0] ADD_CAP = 9'b001000110;
  localparam logic [8:0] SUB_SET = 9'b001001010;
  localparam logic [8:0] SUB_CAP = 9'b001001110;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [8:0] outs();
    return {EnableIn, EnableA, EnableAlu, LatchA, LatchB, AddSub, EnableOut, Busy, Done};
  endfunction

  task automatic check(input string name, input logic [8:0] want);
    logic [8:0] got;
    got = outs();
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: outputs got %b want %b", name, got, want);
    end
  endtask

  // Apply inputs, take one rising edge, check outputs 1 time unit later.
  task automatic step(input logic s, input logic [1:0] o, input logic [8:0] want, input string name);
    Start = s;
    Op    = o;
    @(posedge MainClock);
    #1;
    check(name, want);
  endtask

  task automatic add(input logic s, input logic [1:0] o, input logic [8:0] e);
    vec_t v;
    v.start = s; v.op = o; v.exp = e;
    vecs.push_back(v);
  endtask

  initial begin
    // LOAD_A; Op wiggles after acceptance and must not matter
    add(1, 2'b00, LA_SET);  add(0, 2'b11, LA_CAP); add(1, 2'b10, LA_SET);
    add(1, 2'b01, O_DONE);  add(0, 2'b00, O_IDLE);
    // SUB
    add(1, 2'b11, SUB_SET); add(0, 2'b00, SUB_CAP); add(0, 2'b00, SUB_SET);
    add(0, 2'b00, O_DONE);  add(0, 2'b00, O_IDLE);
    // ADD
    add(1, 2'b10, ADD_SET); add(0, 2'b10, ADD_CAP); add(0, 2'b10, ADD_SET);
    add(0, 2'b10, O_DONE);  add(0, 2'b10, O_IDLE);
    // Start held: LOAD_B then Op switched to ADD while busy; 5-cycle spacing
    add(1, 2'b01, LA_SET);  add(1, 2'b10, LB_CAP); add(1, 2'b10, LA_SET);
    add(1, 2'b10, O_DONE);  add(1, 2'b10, O_IDLE);
    add(1, 2'b10, ADD_SET); add(1, 2'b01, ADD_CAP); add(1, 2'b01, ADD_SET);
    add(1, 2'b01, O_DONE);  add(0, 2'b01, O_IDLE);
    // Idle with Start low stays idle
    add(0, 2'b11, O_IDLE);

    // Reset state, before and while the clock runs
    MainReset = 1'b0; Start = 1'b1; Op = 2'b11;
    #2;  check("reset_t0", O_IDLE);
    #20; check("reset_held", O_IDLE);
    MainReset = 1'b1;   // t=22, between edges

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].start, vecs[i].op, vecs[i].exp, $sformatf("vec%0d", i));

    // Async reset during CAPTURE of LOAD_B
    step(1, 2'b01, LA_SET, "rst_lb_setup");
    step(0, 2'b01, LB_CAP, "rst_lb_capture");
    #2 MainReset = 1'b0;
    #1 check("rst_async_drop", O_IDLE);
    step(1, 2'b10, O_IDLE, "rst_low_edge1");
    step(1, 2'b10, O_IDLE, "rst_low_edge2");
    step(0, 2'b00, O_IDLE, "rst_low_nodone");
    #2 MainReset = 1'b1;
    // First start after release is honoured on the first edge
    step(1, 2'b00, LA_SET, "post_rst_setup");
    step(0, 2'b00, LA_CAP, "post_rst_capture");
    step(0, 2'b00, LA_SET, "post_rst_hold");
    step(0, 2'b00, O_DONE, "post_rst_done");
    step(0, 2'b00, O_IDLE, "post_rst_idle");

    // Random run against a phase model plus bus/capture protocol checks
    begin
      int   ph = 0, acc = 0, dones = 0;
      logic s;
      logic prev_cap = 1'b0, prev_drv = 1'b0;
      for (int i = 0; i < 10000; i++) begin
        s     = 1'($urandom_range(0, 1));
        Start = s;
        Op    = 2'($urandom_range(0, 3));
        @(posedge MainClock);
        #1;
        if (ph == 0) begin
          if (s) begin ph = 1; acc++; end
        end else ph = (ph == 4) ? 0 : ph + 1;
        n_checks++;
        if (($countones({EnableIn, EnableA, EnableAlu}) > 1) || (Done !== (ph == 4)) ||
            (Busy !== (ph >= 1 && ph <= 3))) begin
          n_fail++;
          $display("FAIL rand_state cyc%0d: drv=%b busy=%b done=%b model_phase=%0d",
                   i, {EnableIn, EnableA, EnableAlu}, Busy, Done, ph);
        end
        n_checks++;
        if ((prev_cap && !(EnableIn || EnableAlu)) ||
            ((LatchA || LatchB || EnableOut) && !prev_drv)) begin
          n_fail++;
          $display("FAIL rand_bracket cyc%0d: cap=%b drv=%b prev_cap=%b prev_drv=%b",
                   i, {LatchA, LatchB, EnableOut}, {EnableIn, EnableAlu}, prev_cap, prev_drv);
        end
        if (Done) dones++;
        prev_cap = LatchA || LatchB || EnableOut;
        prev_drv = EnableIn || EnableA || EnableAlu;
      end
      Start = 1'b0;
      repeat (5) begin
        @(posedge MainClock);
        #1;
        if (Done) dones++;
      end
      n_checks++;
      if (dones != acc) begin
        n_fail++;
        $display("FAIL rand_done_count: got %0d dones want %0d accepted", dones, acc);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
